// File: rtl/game_ctrl_if.sv
// Game controller bus: raw flap button in, scene geometry and scores out.
interface game_ctrl_if;
    logic       btn_pressed;
    logic [9:0] bird_y;
    logic [9:0] pipe_x;
    logic [9:0] gap_y;
    logic [7:0] score;
    logic [1:0] state;
    logic [7:0] hi_score;

    modport master (
        input  btn_pressed,
        output bird_y, pipe_x, gap_y, score, state, hi_score
    );

    modport slave (
        output btn_pressed,
        input  bird_y, pipe_x, gap_y, score, state, hi_score
    );
endinterface

// File: rtl/game_ctrl.sv
// Flappy-style game controller: tick-paced bird physics, scrolling pipe, scoring and game FSM.
// Define HISCORE_EN to build the best-score register; otherwise hi_score is tied to zero.
module game_ctrl #(
    parameter int TICK_DIV = 100000,
    parameter int BIRD_X   = 100,
    parameter int BIRD_SZ  = 40,
    parameter int PIPE_W   = 60,
    parameter int GAP_H    = 120,
    parameter int PIPE_SPD = 2,
    parameter int FLAP_VEL = 8,
    parameter int GRAVITY  = 1,
    parameter int MAX_FALL = 10
) (
    input  logic        clk,
    input  logic        rst,
    game_ctrl_if.master gbus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_FALL = 2'd2,
        ST_OVER = 2'd3
    } state_t;

    localparam int                 CNT_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(TICK_DIV - 1);
    localparam logic [10:0]        BIRD_L     = 11'(BIRD_X);
    localparam logic [10:0]        BIRD_S     = 11'(BIRD_SZ);
    localparam logic [10:0]        PIPE_WD    = 11'(PIPE_W);
    localparam logic [10:0]        GAP_HT     = 11'(GAP_H);
    localparam logic [10:0]        PIPE_STEP  = 11'(PIPE_SPD);
    localparam logic [10:0]        FALL_STEP  = 11'(MAX_FALL);
    localparam logic [10:0]        GROUND_Y   = 11'd480;
    localparam logic [10:0]        FLOOR_Y    = GROUND_Y - BIRD_S;
    localparam logic signed [6:0]  VEL_FLAP   = 7'(-FLAP_VEL);
    localparam logic signed [6:0]  VEL_GRAV   = 7'(GRAVITY);
    localparam logic signed [6:0]  VEL_MAX    = 7'(MAX_FALL);
    localparam logic [9:0]         IDLE_Y     = 10'd220;
    localparam logic [9:0]         PIPE_START = 10'd640;
    localparam logic [9:0]         IDLE_GAP   = 10'd180;
    localparam logic [9:0]         GAP_BASE   = 10'd80;
    localparam logic [7:0]         LFSR_SEED  = 8'hA5;

    state_t            state_r, state_s;
    logic              sync1_r, sync2_r, sync_prev_r;
    logic              flap_pend_r, flap_pend_s;
    logic              tick_s, edge_s, consume_s;
    logic [CNT_W-1:0]  tick_cnt_r;
    logic [7:0]        lfsr_r;
    logic [9:0]        bird_y_r, bird_y_s;
    logic [9:0]        pipe_x_r, pipe_x_s;
    logic [9:0]        gap_y_r, gap_y_s;
    logic signed [5:0] vel_r, vel_s;
    logic [7:0]        score_r, score_s;
    logic              scored_r, scored_s;

    logic signed [6:0]  vel_inc_s, vel_play_s;
    logic signed [11:0] y_sum_s;
    logic [10:0]        fall_sum_s;
    logic [9:0]         y_play_s, px_play_s, gy_play_s, y_fall_s;
    logic [7:0]         score_play_s;
    logic               wrap_s, scored_base_s, pass_s, scored_play_s;
    logic               ground_s, overlap_s, out_gap_s, hit_s;

    // Two-flop button synchronizer plus one flop of history for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r     <= 1'b0;
            sync2_r     <= 1'b0;
            sync_prev_r <= 1'b0;
        end else begin
            sync1_r     <= gbus.btn_pressed;
            sync2_r     <= sync1_r;
            sync_prev_r <= sync2_r;
        end
    end

    assign edge_s = sync2_r & ~sync_prev_r;
    assign tick_s = (tick_cnt_r == CNT_LAST);

    // Game tick divider and free-running pseudo-random source for gap height
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_r <= '0;
            lfsr_r     <= LFSR_SEED;
        end else begin
            tick_cnt_r <= tick_s ? '0 : tick_cnt_r + CNT_W'(1);
            lfsr_r     <= {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
        end
    end

    // Candidate positions for a PLAY or FALL tick; all compares widened so nothing wraps
    always_comb begin
        vel_inc_s = $signed({vel_r[5], vel_r}) + VEL_GRAV;
        if (flap_pend_r) begin
            vel_play_s = VEL_FLAP;
        end else if (vel_inc_s > VEL_MAX) begin
            vel_play_s = VEL_MAX;
        end else begin
            vel_play_s = vel_inc_s;
        end

        y_sum_s = $signed({2'b00, bird_y_r}) + $signed({{5{vel_play_s[6]}}, vel_play_s});
        if (y_sum_s[11]) begin
            y_play_s = 10'd0;
        end else if (y_sum_s[10]) begin
            y_play_s = 10'd1023;
        end else begin
            y_play_s = y_sum_s[9:0];
        end

        wrap_s = ({1'b0, pipe_x_r} < PIPE_STEP);
        if (wrap_s) begin
            px_play_s     = PIPE_START;
            gy_play_s     = GAP_BASE + {2'b00, lfsr_r};
            scored_base_s = 1'b0;
        end else begin
            px_play_s     = pipe_x_r - PIPE_STEP[9:0];
            gy_play_s     = gap_y_r;
            scored_base_s = scored_r;
        end

        pass_s        = (({1'b0, px_play_s} + PIPE_WD) < BIRD_L) && !scored_base_s;
        score_play_s  = (pass_s && (score_r != 8'hFF)) ? score_r + 8'd1 : score_r;
        scored_play_s = scored_base_s | pass_s;

        ground_s  = ({1'b0, y_play_s} + BIRD_S) >= GROUND_Y;
        overlap_s = ({1'b0, px_play_s} <= (BIRD_L + BIRD_S)) &&
                    (({1'b0, px_play_s} + PIPE_WD) >= BIRD_L);
        out_gap_s = ({1'b0, y_play_s} < {1'b0, gy_play_s}) ||
                    (({1'b0, y_play_s} + BIRD_S) > ({1'b0, gy_play_s} + GAP_HT));
        hit_s     = ground_s | (overlap_s & out_gap_s);

        fall_sum_s = {1'b0, bird_y_r} + FALL_STEP;
        y_fall_s   = (fall_sum_s >= FLOOR_Y) ? FLOOR_Y[9:0] : fall_sum_s[9:0];
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: state_s = flap_pend_r ? ST_PLAY : ST_IDLE;
            ST_PLAY: state_s = (tick_s && hit_s) ? ST_FALL : ST_PLAY;
            ST_FALL: state_s = (bird_y_r == FLOOR_Y[9:0]) ? ST_OVER : ST_FALL;
            ST_OVER: state_s = flap_pend_r ? ST_IDLE : ST_OVER;
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM output decode: next values of the game datapath and flap request
    always_comb begin
        bird_y_s  = bird_y_r;
        vel_s     = vel_r;
        pipe_x_s  = pipe_x_r;
        gap_y_s   = gap_y_r;
        score_s   = score_r;
        scored_s  = scored_r;
        consume_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                bird_y_s  = IDLE_Y;
                pipe_x_s  = PIPE_START;
                gap_y_s   = IDLE_GAP;
                score_s   = 8'd0;
                scored_s  = 1'b0;
                consume_s = flap_pend_r;
                if (flap_pend_r) begin
                    vel_s = VEL_FLAP[5:0];
                end else begin
                    vel_s = 6'sd0;
                end
            end
            ST_PLAY: begin
                consume_s = tick_s & flap_pend_r;
                if (tick_s) begin
                    vel_s    = vel_play_s[5:0];
                    bird_y_s = y_play_s;
                    pipe_x_s = px_play_s;
                    gap_y_s  = gy_play_s;
                    score_s  = score_play_s;
                    scored_s = scored_play_s;
                end else begin
                    vel_s = vel_r;
                end
            end
            ST_FALL: begin
                if (tick_s) begin
                    bird_y_s = y_fall_s;
                end else begin
                    bird_y_s = bird_y_r;
                end
            end
            ST_OVER: consume_s = flap_pend_r;
            default: consume_s = 1'b0;
        endcase

        // A new edge wins over consumption so it is kept for the following tick
        if (state_r == ST_FALL) begin
            flap_pend_s = 1'b0;
        end else if (edge_s) begin
            flap_pend_s = 1'b1;
        end else if (consume_s) begin
            flap_pend_s = 1'b0;
        end else begin
            flap_pend_s = flap_pend_r;
        end
    end

    // Game datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bird_y_r    <= IDLE_Y;
            vel_r       <= 6'sd0;
            pipe_x_r    <= PIPE_START;
            gap_y_r     <= IDLE_GAP;
            score_r     <= 8'd0;
            scored_r    <= 1'b0;
            flap_pend_r <= 1'b0;
        end else begin
            bird_y_r    <= bird_y_s;
            vel_r       <= vel_s;
            pipe_x_r    <= pipe_x_s;
            gap_y_r     <= gap_y_s;
            score_r     <= score_s;
            scored_r    <= scored_s;
            flap_pend_r <= flap_pend_s;
        end
    end

`ifdef HISCORE_EN
    logic [7:0] hi_score_r;

    // Best score captured as a game ends
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_score_r <= 8'd0;
        end else if ((state_r == ST_FALL) && (state_s == ST_OVER) && (score_r > hi_score_r)) begin
            hi_score_r <= score_r;
        end else begin
            hi_score_r <= hi_score_r;
        end
    end

    assign gbus.hi_score = hi_score_r;
`else
    assign gbus.hi_score = 8'd0;
`endif

    assign gbus.bird_y = bird_y_r;
    assign gbus.pipe_x = pipe_x_r;
    assign gbus.gap_y  = gap_y_r;
    assign gbus.score  = score_r;
    assign gbus.state  = state_r;

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 100000; clk cycles per game tick.
REQ-002 Parameter BIRD_X, default 100; bird left edge (px). Parameter BIRD_SZ, default 40; bird side (px).
REQ-003 Parameters PIPE_W 60, GAP_H 120, PIPE_SPD 2, FLAP_VEL 8, GRAVITY 1, MAX_FALL 10; px or px/tick.
REQ-004 clk  in  1  system clock. rst  in  1  asynchronous reset, active-high.
REQ-005 btn_pressed  in  1  raw flap button, asynchronous to clk.
REQ-006 bird_y  out  10  bird top edge. pipe_x  out  10  pipe left edge. gap_y  out  10  gap top edge.
REQ-007 score  out  8  pipes passed. state  out  2  IDLE=0, PLAY=1, FALL=2, OVER=3. hi_score  out  8  best score.

Function
REQ-008 btn_pressed SHALL pass a 2-FF synchronizer; a rising edge of the synchronized signal SHALL set the flap_pend flag.
REQ-009 The tick counter SHALL count 0..TICK_DIV-1 and assert tick for one clk when at TICK_DIV-1.
REQ-010 An 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5) SHALL advance every clk.
REQ-011 IDLE: bird_y=220, vel=0, pipe_x=640, gap_y=180, score=0; on flap_pend go to PLAY with vel=-FLAP_VEL and clear flap_pend.
REQ-012 PLAY, per tick, vel update: if flap_pend then vel=-FLAP_VEL and clear flap_pend; else vel=min(vel+GRAVITY, MAX_FALL).
REQ-013 PLAY, per tick, position: bird_y=bird_y+vel (new vel), clamped to 0 at the top; vel SHALL be a 6-bit signed value.
REQ-014 PLAY, per tick, pipe: if pipe_x<PIPE_SPD then pipe_x=640, gap_y=80+LFSR, scored=0; else pipe_x-=PIPE_SPD.
REQ-015 Scoring: when pipe_x+PIPE_W<BIRD_X and scored=0, score SHALL increment (saturating at 255) and scored SHALL be set; at most one increment per pipe.
REQ-016 Collision: ground when bird_y+BIRD_SZ>=480; pipe when horizontal overlap [BIRD_X,BIRD_X+BIRD_SZ] with [pipe_x,pipe_x+PIPE_W] and (bird_y<gap_y or bird_y+BIRD_SZ>gap_y+GAP_H).
REQ-017 Collision SHALL be evaluated on updated positions in the same tick; on collision, go to FALL at the next clk; scoring in that tick still applies.
REQ-018 FALL: pipe_x and gap_y frozen; per tick bird_y+=MAX_FALL, clamped to 440; go to OVER when bird_y=440; flap_pend SHALL be cleared and ignored.
REQ-019 OVER: all outputs held; on flap_pend go to IDLE (IDLE values load at the next clk) and clear flap_pend.
REQ-020 Simultaneous tick and new button edge: the edge SHALL be latched into flap_pend and used at the following tick, not the current one.
REQ-021 All arithmetic SHALL be done at 11 bits minimum before clamping; no output SHALL wrap.

Reset
REQ-022 rst SHALL force state=IDLE, the IDLE values of REQ-011, vel=0, flap_pend=0, scored=0, tick counter=0, LFSR=8'hA5, synchronizer=0, and hi_score=0, taking effect immediately, including mid-game.

Configuration
REQ-023 Macro HISCORE_EN defined: hi_score SHALL load score on entry to OVER when score>hi_score; only rst clears it.
REQ-024 HISCORE_EN undefined: hi_score SHALL be constant 0 and no comparator or register SHALL be built.

Verification (TICK_DIV=4)
REQ-025 Reset, then 100 clk with no button -> state=0, bird_y=220, pipe_x=640, score=0.
REQ-026 One press in IDLE -> state=1; first tick gives vel=-7, bird_y=213; second tick gives bird_y=207.
REQ-027 PLAY with no presses -> vel saturates at 10, bird hits ground -> state=2, then state=3 with bird_y=440.
REQ-028 Flap to hold the gap, gap_y forced to 180 -> score=1 exactly once on the tick pipe_x+60 first drops below 100; pipe_x wraps 0->640.
REQ-029 Assert rst mid-PLAY, then release -> immediate IDLE values; with HISCORE_EN, hi_score=0 after rst and retains 1 after a later game over with score 1.
